// File: rtl/ktms_retry_pkg.sv
// Shared encodings and default widths for the retry scheduler.
package ktms_retry_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StIssue = 2'd2
  } state_e;

  localparam int unsigned TsWidthDef   = 64;
  localparam int unsigned EaWidthDef   = 65;
  localparam int unsigned CtxtWidthDef = 10;
  localparam int unsigned DlyWidthDef  = 16;

  localparam int unsigned IssueCntW = 32;
  localparam int unsigned FlushCntW = 16;

endpackage

// File: rtl/ktms_retry_age_cmp.sv
// Backoff check: true once (now - ts) mod 2^ts_width reaches the zero-extended delay.
module ktms_retry_age_cmp #(
  parameter int unsigned ts_width  = 64,
  parameter int unsigned dly_width = 16
) (
  input  logic [ts_width-1:0]  i_now,
  input  logic [ts_width-1:0]  i_ts,
  input  logic [dly_width-1:0] i_delay,
  output logic                 o_ok
);

  logic [ts_width-1:0] age;

  // Modulo subtraction keeps the age correct across a timestamp wrap.
  assign age  = i_now - i_ts;
  assign o_ok = (age >= ts_width'(i_delay));

endmodule

// File: rtl/ktms_retry_sched.sv
// Retry scheduler: holds one command, waits for enable (and backoff age when
// KTMS_RETRY_SCHED_DELAY_EN is defined), then issues a re-fetch request.
module ktms_retry_sched
  import ktms_retry_pkg::*;
#(
  parameter int unsigned ts_width   = TsWidthDef,
  parameter int unsigned ea_width   = EaWidthDef,
  parameter int unsigned ctxt_width = CtxtWidthDef,
  parameter int unsigned dly_width  = DlyWidthDef
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   i_v,
  output logic                                   i_r,
  input  logic [ts_width+ea_width+ctxt_width-1:0] i_d,
  input  logic [ts_width-1:0]                    i_now,
  input  logic [dly_width-1:0]                   i_delay,
  input  logic                                   i_enable,
  input  logic                                   i_flush,
  output logic                                   o_v,
  input  logic                                   o_r,
  output logic [ea_width-1:0]                    o_ea,
  output logic [ctxt_width-1:0]                  o_ctxt,
  output logic                                   o_busy,
  output logic [IssueCntW-1:0]                   o_issue_cnt,
  output logic [FlushCntW-1:0]                   o_flush_cnt
);

  localparam int unsigned DWidth = ts_width + ea_width + ctxt_width;

  state_e                state_q, state_d;
  logic [DWidth-1:0]     held_q, held_d;
  logic [IssueCntW-1:0]  issue_cnt_q, issue_cnt_d;
  logic [FlushCntW-1:0]  flush_cnt_q, flush_cnt_d;
  logic                  busy_q;
  logic [ts_width-1:0]   held_ts;
  logic                  age_ok;

  assign held_ts = held_q[DWidth-1 -: ts_width];
  assign o_ea    = held_q[ea_width+ctxt_width-1 : ctxt_width];
  assign o_ctxt  = held_q[ctxt_width-1:0];

`ifdef KTMS_RETRY_SCHED_DELAY_EN
  ktms_retry_age_cmp #(
    .ts_width  (ts_width),
    .dly_width (dly_width)
  ) u_age_cmp (
    .i_now   (i_now),
    .i_ts    (held_ts),
    .i_delay (i_delay),
    .o_ok    (age_ok)
  );
`else
  logic unused_age;
  assign age_ok     = 1'b1;
  assign unused_age = ^{i_now, i_delay, held_ts};
`endif

  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    issue_cnt_d = issue_cnt_q;
    flush_cnt_d = flush_cnt_q;
    i_r         = 1'b0;
    o_v         = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Flush has no effect here; a capture still proceeds.
        i_r = 1'b1;
        if (i_v) begin
          held_d  = i_d;
          state_d = StWait;
        end
      end
      StWait: begin
        if (i_flush) begin
          state_d = StIdle;
          if (!(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + FlushCntW'(1);
        end else if (i_enable && age_ok) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Flush outranks a simultaneous handshake and masks o_v this cycle.
        if (i_flush) begin
          state_d = StIdle;
          if (!(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + FlushCntW'(1);
        end else begin
          o_v = 1'b1;
          if (o_r) begin
            state_d = StIdle;
            if (!(&issue_cnt_q)) issue_cnt_d = issue_cnt_q + IssueCntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      held_q      <= '0;
      issue_cnt_q <= '0;
      flush_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      issue_cnt_q <= issue_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      busy_q      <= (state_d != StIdle);
    end
  end

  assign o_busy      = busy_q;
  assign o_issue_cnt = issue_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ktms_retry_sched.sv
// Directed bench for ktms_retry_sched; age-compare steps run only when
// KTMS_RETRY_SCHED_DELAY_EN is defined.
module tb_ktms_retry_sched;

  localparam int unsigned TW = 64;
  localparam int unsigned EW = 65;
  localparam int unsigned CW = 10;
  localparam int unsigned DW = 16;

  localparam logic [EW-1:0] EA1 = 65'h1_DEAD_BEEF_0000_1001;
  localparam logic [EW-1:0] EA2 = 65'h0_1234_5678_9ABC_DEF1;
  localparam logic [EW-1:0] EA3 = 65'h1_0000_0000_0000_0003;
  localparam logic [EW-1:0] EA4 = 65'h0_4444_4444_4444_4445;
  localparam logic [EW-1:0] EA5 = 65'h1_5555_AAAA_5555_AAA5;
  localparam logic [CW-1:0] CT1 = 10'h2A5;
  localparam logic [CW-1:0] CT2 = 10'h15A;
  localparam logic [CW-1:0] CT5 = 10'h3C3;

  logic              clk;
  logic              reset;
  logic              i_v;
  logic              i_r;
  logic [TW+EW+CW-1:0] i_d;
  logic [TW-1:0]     i_now;
  logic [DW-1:0]     i_delay;
  logic              i_enable;
  logic              i_flush;
  logic              o_v;
  logic              o_r;
  logic [EW-1:0]     o_ea;
  logic [CW-1:0]     o_ctxt;
  logic              o_busy;
  logic [31:0]       o_issue_cnt;
  logic [15:0]       o_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  ktms_retry_sched dut (
    .clk         (clk),
    .reset       (reset),
    .i_v         (i_v),
    .i_r         (i_r),
    .i_d         (i_d),
    .i_now       (i_now),
    .i_delay     (i_delay),
    .i_enable    (i_enable),
    .i_flush     (i_flush),
    .o_v         (o_v),
    .o_r         (o_r),
    .o_ea        (o_ea),
    .o_ctxt      (o_ctxt),
    .o_busy      (o_busy),
    .o_issue_cnt (o_issue_cnt),
    .o_flush_cnt (o_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; i_v = 1'b0; i_d = '0; i_now = '0; i_delay = '0;
    i_enable = 1'b0; i_flush = 1'b0; o_r = 1'b0;
    #12;
    chk("rst_busy", 128'(o_busy), 128'(0));
    chk("rst_ir",   128'(i_r),    128'(1));
    chk("rst_ov",   128'(o_v),    128'(0));
    chk("rst_icnt", 128'(o_issue_cnt), 128'(0));
    chk("rst_fcnt", 128'(o_flush_cnt), 128'(0));
    chk("rst_ea",   128'(o_ea),   128'(0));
    nxt(); reset = 1'b1;

    // Capture, then hold enable low for 5 cycles.
    nxt(); i_v = 1'b1; i_d = {64'd5, EA1, CT1}; #1;
    chk("cap_ir", 128'(i_r), 128'(1));
    nxt(); i_v = 1'b0; #1;
    chk("wait_busy", 128'(o_busy), 128'(1));
    chk("wait_ir",   128'(i_r),    128'(0));
    for (int k = 0; k < 5; k++) begin
      nxt(); i_now = {$urandom, $urandom}; #1;
      chk("dis_ov", 128'(o_v), 128'(0));
    end
    nxt(); i_enable = 1'b1; i_now = {$urandom, $urandom}; #1;
    chk("en_ov_same", 128'(o_v), 128'(0));
    nxt(); i_enable = 1'b0; #1;
    chk("iss_ov",   128'(o_v),    128'(1));
    chk("iss_ea",   128'(o_ea),   128'(EA1));
    chk("iss_ctxt", 128'(o_ctxt), 128'(CT1));

    // Backpressure for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      nxt(); #1;
      chk("stall_ov",   128'(o_v),    128'(1));
      chk("stall_ea",   128'(o_ea),   128'(EA1));
      chk("stall_ctxt", 128'(o_ctxt), 128'(CT1));
    end
    nxt(); o_r = 1'b1; #1;
    chk("hs_ov", 128'(o_v), 128'(1));
    nxt(); o_r = 1'b0; #1;
    chk("hs_icnt", 128'(o_issue_cnt), 128'(1));
    chk("hs_busy", 128'(o_busy),      128'(0));
    chk("hs_ir",   128'(i_r),         128'(1));
    chk("hs_ov0",  128'(o_v),         128'(0));

    // Flush together with o_r in ISSUE.
    nxt(); i_v = 1'b1; i_d = {64'd7, EA2, CT2}; i_enable = 1'b1;
    nxt(); i_v = 1'b0;
    nxt(); #1;
    chk("fr_pre_ov", 128'(o_v), 128'(1));
    i_flush = 1'b1; o_r = 1'b1; i_enable = 1'b0; #1;
    chk("fr_ov_mask", 128'(o_v), 128'(0));
    nxt(); i_flush = 1'b0; o_r = 1'b0; #1;
    chk("fr_fcnt", 128'(o_flush_cnt), 128'(1));
    chk("fr_icnt", 128'(o_issue_cnt), 128'(1));
    chk("fr_ir",   128'(i_r),         128'(1));
    chk("fr_busy", 128'(o_busy),      128'(0));

    // Flush in WAIT.
    nxt(); i_v = 1'b1; i_d = {64'd9, EA3, CT1};
    nxt(); i_v = 1'b0; i_flush = 1'b1; #1;
    chk("fw_ov", 128'(o_v), 128'(0));
    nxt(); i_flush = 1'b0; #1;
    chk("fw_fcnt", 128'(o_flush_cnt), 128'(2));
    chk("fw_busy", 128'(o_busy),      128'(0));

    // Flush in IDLE does not block the capture.
    nxt(); i_v = 1'b1; i_flush = 1'b1; i_d = {64'd11, EA4, CT2};
    nxt(); i_v = 1'b0; i_flush = 1'b0; #1;
    chk("fi_busy", 128'(o_busy),      128'(1));
    chk("fi_fcnt", 128'(o_flush_cnt), 128'(2));

    // Asynchronous reset mid-WAIT drops EA4.
    #2 reset = 1'b0; #1;
    chk("ra_busy", 128'(o_busy),      128'(0));
    chk("ra_ir",   128'(i_r),         128'(1));
    chk("ra_icnt", 128'(o_issue_cnt), 128'(0));
    chk("ra_fcnt", 128'(o_flush_cnt), 128'(0));
    nxt(); reset = 1'b1;
    nxt(); i_v = 1'b1; i_d = {64'd13, EA5, CT5}; i_enable = 1'b1;
    nxt(); i_v = 1'b0;
    nxt(); #1;
    chk("rn_ov",   128'(o_v),    128'(1));
    chk("rn_ea",   128'(o_ea),   128'(EA5));
    chk("rn_ctxt", 128'(o_ctxt), 128'(CT5));
    o_r = 1'b1;
    nxt(); o_r = 1'b0; i_enable = 1'b0; #1;
    chk("rn_icnt", 128'(o_issue_cnt), 128'(1));
    chk("rn_busy", 128'(o_busy),      128'(0));

`ifdef KTMS_RETRY_SCHED_DELAY_EN
    // Backoff age: 1099 - 1000 < 100, 1100 - 1000 >= 100.
    nxt(); i_delay = 16'd100; i_now = 64'd1000; i_enable = 1'b1;
    i_v = 1'b1; i_d = {64'd1000, EA2, CT2};
    nxt(); i_v = 1'b0; i_now = 64'd1099;
    for (int k = 0; k < 4; k++) begin
      nxt(); #1;
      chk("age_hold_ov", 128'(o_v), 128'(0));
    end
    i_now = 64'd1100;
    nxt(); #1;
    chk("age_ov", 128'(o_v), 128'(1));
    o_r = 1'b1;
    nxt(); o_r = 1'b0; #1;
    chk("age_icnt", 128'(o_issue_cnt), 128'(2));

    // Wrap: age 0x0F-0x..F0 = 31 < 32, 0x10-0x..F0 = 32.
    nxt(); i_delay = 16'd32; i_now = 64'hFFFF_FFFF_FFFF_FFF0;
    i_v = 1'b1; i_d = {64'hFFFF_FFFF_FFFF_FFF0, EA1, CT1};
    nxt(); i_v = 1'b0; i_now = 64'h0F;
    for (int k = 0; k < 3; k++) begin
      nxt(); #1;
      chk("wrap_hold_ov", 128'(o_v), 128'(0));
      chk("wrap_busy",    128'(o_busy), 128'(1));
    end
    i_now = 64'h10;
    nxt(); #1;
    chk("wrap_ov", 128'(o_v),  128'(1));
    chk("wrap_ea", 128'(o_ea), 128'(EA1));
    o_r = 1'b1;
    nxt(); o_r = 1'b0; i_enable = 1'b0; #1;
    chk("wrap_icnt", 128'(o_issue_cnt), 128'(3));
`endif

    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
